vga_timing: RTL



---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_timing_if.sv | 28 ++
 rtl/vga_timing_sync_axis.sv | 73 +++++++
 rtl/vga_timing.sv | 90 +++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants for the 640x480@60 VGA timing generator.
//   - Default horizontal/vertical segment lengths and derived totals.
//   - Sync polarity and the foreground/background colours.
//   - 2-bit encoding of the per-axis segment FSM, shared by both axes.
package vga_timing_pkg;

  localparam int CNT_W    = 12;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic        SYNC_ACTIVE = 1'b0;
  localparam logic [11:0] FG_RGB      = 12'hFFF;
  localparam logic [11:0] BG_RGB      = 12'h000;

  // Segment of one raster axis; the same encoding serves H and V.
  typedef enum logic [1:0] {
    ST_ACT  = 2'd0,
    ST_FP   = 2'd1,
    ST_SYNC = 2'd2,
    ST_BP   = 2'd3
  } axis_state_t;

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: signals between the timing generator, the renderer and the
// VGA connector.
//   master (timing generator): drives vga_x, vga_y, video_on, frame_tick,
//                              hsync, vsync, rgb; reads pixel.
//   slave  (renderer/sink):    drives pixel; reads everything else.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic             pixel;
  logic [CNT_W-1:0] vga_x;
  logic [CNT_W-1:0] vga_y;
  logic             video_on;
  logic             frame_tick;
  logic             hsync;
  logic             vsync;
  logic [11:0]      rgb;

  modport master (
    input  pixel,
    output vga_x, vga_y, video_on, frame_tick, hsync, vsync, rgb
  );

  modport slave (
    output pixel,
    input  vga_x, vga_y, video_on, frame_tick, hsync, vsync, rgb
  );

endinterface

// File: rtl/vga_timing_sync_axis.sv
// sync_axis: one raster axis -- a position counter plus a 4-segment FSM
// (active, front porch, sync, back porch).
//   clk, rst_n : clock, async active-low reset
//   adv        : advance one position this cycle
//   count      : current position, 0..TOTAL-1
//   in_active  : current position is in the active segment
//   in_sync    : current position is in the sync segment
//   at_end     : count is at TOTAL-1 (wraps on the next advance)
//
// state   | meaning
// --------+-------------------------------
// ST_ACT  | visible region, 0..ACTIVE-1
// ST_FP   | front porch
// ST_SYNC | sync pulse
// ST_BP   | back porch, ends at TOTAL-1
module sync_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [CNT_W-1:0] count,
  output logic             in_active,
  output logic             in_sync,
  output logic             at_end
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST_ACT  = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_FP   = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);

  axis_state_t      state, state_nxt;
  logic [CNT_W-1:0] count_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACT;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Segment changes on the same advance that moves count past the segment's
  // last position, so state always describes the position in count.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (adv) begin
      count_nxt = at_end ? '0 : count + 1'b1;
      unique case (state)
        ST_ACT:  if (count == LAST_ACT)  state_nxt = ST_FP;
        ST_FP:   if (count == LAST_FP)   state_nxt = ST_SYNC;
        ST_SYNC: if (count == LAST_SYNC) state_nxt = ST_BP;
        ST_BP:   if (at_end)             state_nxt = ST_ACT;
        default:                         state_nxt = ST_ACT;
      endcase
    end
  end

  assign at_end    = (count == LAST);
  assign in_active = (state == ST_ACT);
  assign in_sync   = (state == ST_SYNC);

endmodule

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster generator and VGA output stage.
//   pixel_clk : pixel clock (only clock)
//   rst_n     : async active-low reset
//   vif       : vga_timing_if.master -- vga_x/vga_y/video_on/frame_tick to
//               the renderer, pixel back from it, hsync/vsync/rgb to the
//               connector.
// Outputs hsync/vsync/rgb lag the presented position by one cycle, matching
// the renderer's registered pixel.
// Build option VGA_TEST_PATTERN_EN: replaces the pixel input with an internal
// 16x16 checkerboard for bring-up without the renderer.
module vga_timing #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic         pixel_clk,
  input  logic         rst_n,
  vga_timing_if.master vif
);

  localparam int          W       = vga_timing_pkg::CNT_W;
  localparam logic        SYNC_ON = vga_timing_pkg::SYNC_ACTIVE;
  localparam logic [11:0] FG      = vga_timing_pkg::FG_RGB;
  localparam logic [11:0] BG      = vga_timing_pkg::BG_RGB;

  logic [W-1:0] h_cnt, v_cnt;
  logic         h_active, h_in_sync, h_at_end;
  logic         v_active, v_in_sync, v_at_end_unused;
  logic         active_q, hsync_q, vsync_q, frame_tick_q;
  logic         pix;

  sync_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(pixel_clk), .rst_n(rst_n), .adv(1'b1),
    .count(h_cnt), .in_active(h_active), .in_sync(h_in_sync), .at_end(h_at_end)
  );

  sync_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(pixel_clk), .rst_n(rst_n), .adv(h_at_end),
    .count(v_cnt), .in_active(v_active), .in_sync(v_in_sync),
    .at_end(v_at_end_unused)
  );

  assign vif.vga_x    = h_cnt;
  assign vif.vga_y    = v_cnt;
  assign vif.video_on = h_active && v_active;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q     <= 1'b0;
      hsync_q      <= ~SYNC_ON;
      vsync_q      <= ~SYNC_ON;
      frame_tick_q <= 1'b0;
    end else begin
      active_q     <= h_active && v_active;
      hsync_q      <= h_in_sync ? SYNC_ON : ~SYNC_ON;
      vsync_q      <= v_in_sync ? SYNC_ON : ~SYNC_ON;
      frame_tick_q <= h_at_end && (v_cnt == W'(V_ACTIVE - 1));
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic pattern_q;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) pattern_q <= 1'b0;
    else        pattern_q <= h_cnt[4] ^ v_cnt[4];
  end

  assign pix = pattern_q;
`else
  assign pix = vif.pixel;
`endif

  // pix and active_q both describe the previous position and are register
  // outputs, so rgb changes on the same edge as hsync/vsync.
  assign vif.rgb        = active_q ? (pix ? FG : BG) : 12'h000;
  assign vif.hsync      = hsync_q;
  assign vif.vsync      = vsync_q;
  assign vif.frame_tick = frame_tick_q;

endmodule
